// File: rtl/iter_fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer.
// Walks every stage of the transform and, for each butterfly, issues a read of
// the A/B operand pair plus the matching twiddle index. One cycle later it writes
// the butterfly results back to the same two addresses. A single bubble cycle
// between stages lets the last write of a stage land before the next stage reads.
module iter_fft_ctrl #(
    parameter int LOG2_POINTS = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_rd_en,
    output logic [LOG2_POINTS-1:0] o_rd_addr_a,
    output logic [LOG2_POINTS-1:0] o_rd_addr_b,
    output logic [LOG2_POINTS-2:0] o_tw_addr,
    output logic                   o_wr_en,
    output logic [LOG2_POINTS-1:0] o_wr_addr_x,
    output logic [LOG2_POINTS-1:0] o_wr_addr_y,
    output logic [LOG2_POINTS-1:0] o_stage
);

    localparam int L = LOG2_POINTS;
    localparam logic [L-1:0] LAST_STAGE = L'(L - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [L-1:0]   s_q, s_d;       // stage index
    logic [L-2:0]   k_q, k_d;       // butterfly index within the stage

    // Address generation for the current (s, k)
    logic [L-1:0]   half_span;
    logic [L-1:0]   span_mask;
    logic [L-1:0]   k_ext;
    logic [L-1:0]   s_plus1;
    logic [L-1:0]   base_a;
    logic [L-1:0]   addr_a;
    logic [L-1:0]   addr_b;
    logic [L-2:0]   tw_idx;

    // Read-side strobes, registered into the write side
    logic           rd_en;
    logic           wr_en_q;
    logic [L-1:0]   wr_addr_x_q;
    logic [L-1:0]   wr_addr_y_q;

    assign half_span = L'(1) << s_q;
    assign span_mask = half_span - L'(1);
    assign k_ext     = {1'b0, k_q};
    assign s_plus1   = s_q + L'(1);
    // Group number (k >> s) selects a block of 2h entries; j = k & (h-1) is the offset inside it.
    // In the last stage s+1 equals L and the shift clears the base, which is correct since k < P/2.
    assign base_a    = (k_ext >> s_q) << s_plus1;
    assign addr_a    = base_a | (k_ext & span_mask);
    assign addr_b    = addr_a + half_span;
    // j < 2^s, so j << (L-1-s) always fits in L-1 bits.
    assign tw_idx    = (k_q & span_mask[L-2:0]) << (LAST_STAGE - s_q);

    // State and loop counters
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            ST_RUN: begin
                k_d = k_q + 1'b1;
                if (&k_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (s_q == LAST_STAGE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                    s_d     = s_q + L'(1);
                    k_d     = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                s_d     = '0;
                k_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                k_d     = '0;
            end
        endcase
    end

    // Status and read-side outputs; addresses are held at zero outside RUN
    always_comb begin
        o_busy      = (state_q != ST_IDLE);
        o_done      = (state_q == ST_DONE);
        rd_en       = 1'b0;
        o_rd_addr_a = '0;
        o_rd_addr_b = '0;
        o_tw_addr   = '0;
        if (state_q == ST_RUN) begin
            rd_en       = 1'b1;
            o_rd_addr_a = addr_a;
            o_rd_addr_b = addr_b;
            o_tw_addr   = tw_idx;
        end
    end

    // Write side trails the read side by the one-cycle RAM/ROM latency
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_en_q     <= 1'b0;
            wr_addr_x_q <= '0;
            wr_addr_y_q <= '0;
        end else begin
            wr_en_q     <= rd_en;
            wr_addr_x_q <= o_rd_addr_a;
            wr_addr_y_q <= o_rd_addr_b;
        end
    end

    assign o_rd_en     = rd_en;
    assign o_wr_en     = wr_en_q;
    assign o_wr_addr_x = wr_addr_x_q;
    assign o_wr_addr_y = wr_addr_y_q;
    assign o_stage     = s_q;

endmodule

// File: tb/tb_iter_fft_ctrl.sv
// Directed bench for iter_fft_ctrl with P=16, including a behavioural
// working RAM, twiddle ROM and butterfly (1/2 scaling per stage).
module tb_iter_fft_ctrl;

    localparam int L = 4;
    localparam int P = 16;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic         o_busy, o_done, o_rd_en, o_wr_en;
    logic [L-1:0] o_rd_addr_a, o_rd_addr_b, o_wr_addr_x, o_wr_addr_y, o_stage;
    logic [L-2:0] o_tw_addr;

    int checks   = 0;
    int failures = 0;
    int n;
    int wr_cnt;

    iter_fft_ctrl #(.LOG2_POINTS(L)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rd_en     (o_rd_en),
        .o_rd_addr_a (o_rd_addr_a),
        .o_rd_addr_b (o_rd_addr_b),
        .o_tw_addr   (o_tw_addr),
        .o_wr_en     (o_wr_en),
        .o_wr_addr_x (o_wr_addr_x),
        .o_wr_addr_y (o_wr_addr_y),
        .o_stage     (o_stage)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- memory / butterfly model ----------------
    int   mem_re [P];
    int   mem_im [P];
    int   a_re, a_im, b_re, b_im;
    logic [L-2:0] tw_q;
    logic load_mem = 1'b0;
    int   wb_re, wb_im, x_re, x_im, y_re, y_im;

    function automatic int w_re(input int i);
        case (i)
            0: return 32767;   1: return 30273;   2: return 23170;  3: return 12540;
            4: return 0;       5: return -12540;  6: return -23170;
            default: return -30273;
        endcase
    endfunction

    function automatic int w_im(input int i);
        case (i)
            0: return 0;       1: return -12540;  2: return -23170; 3: return -30273;
            4: return -32767;  5: return -30273;  6: return -23170;
            default: return -12540;
        endcase
    endfunction

    always_comb begin
        wb_re = (b_re * w_re(int'(tw_q)) - b_im * w_im(int'(tw_q))) >>> 15;
        wb_im = (b_re * w_im(int'(tw_q)) + b_im * w_re(int'(tw_q))) >>> 15;
        x_re  = (a_re + wb_re) >>> 1;
        x_im  = (a_im + wb_im) >>> 1;
        y_re  = (a_re - wb_re) >>> 1;
        y_im  = (a_im - wb_im) >>> 1;
    end

    always @(posedge i_clk) begin
        if (load_mem) begin
            for (int i = 0; i < P; i++) begin
                mem_re[i] <= (i == 0) ? 32'sh4000 : 0;
                mem_im[i] <= 0;
            end
        end else begin
            if (o_rd_en) begin
                a_re <= mem_re[o_rd_addr_a];
                a_im <= mem_im[o_rd_addr_a];
                b_re <= mem_re[o_rd_addr_b];
                b_im <= mem_im[o_rd_addr_b];
                tw_q <= o_tw_addr;
            end
            if (o_wr_en) begin
                mem_re[o_wr_addr_x] <= x_re;
                mem_im[o_wr_addr_x] <= x_im;
                mem_re[o_wr_addr_y] <= y_re;
                mem_im[o_wr_addr_y] <= y_im;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, n, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_rd_en"}, o_rd_en, 0);
        chk({tag, "_wr_en"}, o_wr_en, 0);
        chk({tag, "_rd_a"}, o_rd_addr_a, 0);
        chk({tag, "_rd_b"}, o_rd_addr_b, 0);
        chk({tag, "_tw"}, o_tw_addr, 0);
        chk({tag, "_wr_x"}, o_wr_addr_x, 0);
        chk({tag, "_wr_y"}, o_wr_addr_y, 0);
        chk({tag, "_stage"}, o_stage, 0);
    endtask

    task automatic chk_rd(input string tag, input int a, input int b, input int tw, input int s);
        chk({tag, "_rd_en"}, o_rd_en, 1);
        chk({tag, "_rd_a"}, o_rd_addr_a, a);
        chk({tag, "_rd_b"}, o_rd_addr_b, b);
        chk({tag, "_tw"}, o_tw_addr, tw);
        chk({tag, "_stage"}, o_stage, s);
    endtask

    task automatic chk_wr(input string tag, input int x, input int y);
        chk({tag, "_wr_en"}, o_wr_en, 1);
        chk({tag, "_wr_x"}, o_wr_addr_x, x);
        chk({tag, "_wr_y"}, o_wr_addr_y, y);
    endtask

    // Full run from a start pulse through cycle 40; optional start re-pulses in cycles 5 and 37.
    task automatic run_full(input string tag, input bit repulse);
        i_start = 1'b1;
        tick();                        // edge 0 sampled the start
        wr_cnt = 0;
        for (n = 1; n <= 40; n++) begin
            i_start = (repulse && (n == 5 || n == 37)) ? 1'b1 : 1'b0;
            chk({tag, "_rd_en"}, o_rd_en, (n <= 36) && (n % 9 != 0));
            chk({tag, "_done"}, o_done, n == 37);
            chk({tag, "_busy"}, o_busy, n <= 37);
            if (o_wr_en) wr_cnt++;
            case (n)
                1:  chk_rd({tag, "_s0k0"}, 0, 1, 0, 0);
                2:  chk_wr({tag, "_s0k0"}, 0, 1);
                9:  chk_wr({tag, "_drain0"}, 14, 15);
                11: chk_rd({tag, "_s1k1"}, 1, 3, 4, 1);
                12: chk_wr({tag, "_s1k1"}, 1, 3);
                24: chk_rd({tag, "_s2k5"}, 9, 13, 2, 2);
                25: chk_wr({tag, "_s2k5"}, 9, 13);
                33: chk_rd({tag, "_s3k5"}, 5, 13, 5, 3);
                34: chk_wr({tag, "_s3k5"}, 5, 13);
                36: chk_wr({tag, "_drain3"}, 7, 15);
                default: ;
            endcase
            tick();
        end
        i_start = 1'b0;
        chk({tag, "_wr_pulses"}, wr_cnt, 32);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n = 0;
        // Reset held for 3 cycles, memory preloaded with an impulse in the meantime
        i_rst_n  = 1'b0;
        load_mem = 1'b1;
        tick(); tick(); tick();
        load_mem = 1'b0;
        chk_idle("reset");
        i_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_idle("idle");
        end

        // Run 1: addressing, framing and the end-to-end impulse transform
        run_full("run1", 1'b0);
        for (int b = 0; b < P; b++) begin
            chk($sformatf("bin%0d_re", b), mem_re[b], 32'h400);
            chk($sformatf("bin%0d_im", b), mem_im[b], 0);
        end

        // Run 2: start re-pulsed during the run and in the done cycle
        run_full("repulse", 1'b1);

        // Run 3: reset dropped in cycle 12
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (n = 1; n < 12; n++) tick();
        chk("rst12_pre_rd_en", o_rd_en, 1);
        chk("rst12_pre_stage", o_stage, 1);
        i_rst_n = 1'b0;
        tick();
        n = 13;
        chk_idle("rst12");
        i_rst_n = 1'b1;
        tick();
        chk_idle("rst12_after");

        // Fresh start reproduces the complete sequence
        run_full("rerun", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
